// File: rtl/axis_ifmaps_rx.sv
// axis_ifmaps_rx
//   AXI-Stream slave front end for the ifmaps path. Incoming beats are held in a
//   2-entry skid buffer and forwarded to the ifmaps preload packer with a load
//   strobe whenever the packer FIFO has room. Beats and vectors are counted per
//   frame, and completion is flagged with a 1-cycle frame_done pulse.
//
//   Optional build macro: AXIS_IFMAPS_RX_TLAST_CHECK_EN
//     defined   : err_tlast flags an early or missing TLAST (sticky until the
//                 next accepted cfg_start)
//     undefined : s_axis_tlast is ignored and err_tlast is tied low
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   s_axis_*             AXIS slave (tdata/tvalid/tready/tlast); tready is registered
//   cfg_start            1-cycle pulse that latches the config and starts a frame
//   input_channel_size   channels per ifmap vector (beats/vector = C/6 + 1)
//   vector_count         ifmap vectors per frame
//   ifmaps_to_preload    skid-buffer head presented to the packer
//   load_ifmaps_preload  packer write strobe
//   preload_fifo_full    packer FIFO full (back-pressure)
//   busy                 high in CFG/RUN
//   frame_done           1-cycle pulse after the final beat is forwarded
//   err_tlast            sticky TLAST placement error
//
// state | meaning
// IDLE  | waiting for a cfg_start carrying a non-zero config
// CFG   | derive beats per vector, clear frame counters
// RUN   | accept beats into the skid buffer and forward them to the packer
// DONE  | pulse frame_done, return to IDLE
module axis_ifmaps_rx #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int VEC_CNT_W            = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   input  logic                            cfg_start,
   input  logic [11:0]                     input_channel_size,
   input  logic [VEC_CNT_W-1:0]            vector_count,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0] ifmaps_to_preload,
   output logic                            load_ifmaps_preload,
   input  logic                            preload_fifo_full,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            err_tlast
);

   typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_RUN, ST_DONE} state_t;

   state_t                            state_q, state_d;
   logic [11:0]                       chan_q;
   logic [VEC_CNT_W-1:0]              vec_total_q;
   logic [11:0]                       bpv_q;
   logic [11:0]                       in_beat_q, out_beat_q;
   logic [VEC_CNT_W-1:0]              in_vec_q, out_vec_q;
   logic                              in_done_q, in_done_d;
   logic [C_S_AXIS_TDATA_WIDTH-1:0]   skid_mem [0:1];
   logic                              rd_ptr_q, wr_ptr_q;
   logic [1:0]                        occ_q, occ_d;
   logic                              tready_q;

   logic cfg_ok;
   logic accept;
   logic load;
   logic in_last;
   logic out_last;

   assign cfg_ok   = cfg_start && (input_channel_size != 12'd0) && (vector_count != '0);
   assign accept   = (state_q == ST_RUN) && s_axis_tvalid && tready_q;
   assign load     = (state_q == ST_RUN) && (occ_q != 2'd0) && !preload_fifo_full;
   assign in_last  = (in_beat_q == bpv_q - 12'd1) && (in_vec_q == vec_total_q - VEC_CNT_W'(1));
   assign out_last = (out_beat_q == bpv_q - 12'd1) && (out_vec_q == vec_total_q - VEC_CNT_W'(1));

   assign s_axis_tready       = tready_q;
   assign load_ifmaps_preload = load;
   assign ifmaps_to_preload   = skid_mem[rd_ptr_q];
   assign busy                = (state_q == ST_CFG) || (state_q == ST_RUN);
   assign frame_done          = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_done_d = in_done_q;
      occ_d     = occ_q + {1'b0, accept} - {1'b0, load};
      case (state_q)
         ST_IDLE: if (cfg_ok) state_d = ST_CFG;
         ST_CFG: begin
            state_d   = ST_RUN;
            in_done_d = 1'b0;
            occ_d     = 2'd0;
         end
         ST_RUN: begin
            if (accept && in_last) in_done_d = 1'b1;
            if (load && out_last)  state_d   = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // tready is computed from next-cycle occupancy so a full skid or a
   // completed frame never sees another beat accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_q      <= '0;
         vec_total_q <= '0;
         bpv_q       <= '0;
         in_beat_q   <= '0;
         in_vec_q    <= '0;
         out_beat_q  <= '0;
         out_vec_q   <= '0;
         in_done_q   <= 1'b0;
         tready_q    <= 1'b0;
      end else begin
         in_done_q <= in_done_d;
         tready_q  <= (state_d == ST_RUN) && !in_done_d && (occ_d != 2'd2);
         case (state_q)
            ST_IDLE: begin
               if (cfg_ok) begin
                  chan_q      <= input_channel_size;
                  vec_total_q <= vector_count;
               end
            end
            ST_CFG: begin
               bpv_q      <= chan_q / 12'd6 + 12'd1;
               in_beat_q  <= '0;
               in_vec_q   <= '0;
               out_beat_q <= '0;
               out_vec_q  <= '0;
            end
            ST_RUN: begin
               if (accept) begin
                  if (in_beat_q == bpv_q - 12'd1) begin
                     in_beat_q <= '0;
                     in_vec_q  <= in_vec_q + VEC_CNT_W'(1);
                  end else begin
                     in_beat_q <= in_beat_q + 12'd1;
                  end
               end
               if (load) begin
                  if (out_beat_q == bpv_q - 12'd1) begin
                     out_beat_q <= '0;
                     out_vec_q  <= out_vec_q + VEC_CNT_W'(1);
                  end else begin
                     out_beat_q <= out_beat_q + 12'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         occ_q <= occ_d;
         if (state_q == ST_CFG) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            if (accept) begin
               skid_mem[wr_ptr_q] <= s_axis_tdata;
               wr_ptr_q           <= ~wr_ptr_q;
            end
            if (load) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

`ifdef AXIS_IFMAPS_RX_TLAST_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                err_q <= 1'b0;
      else if ((state_q == ST_IDLE) && cfg_ok)   err_q <= 1'b0;
      else if (accept && (s_axis_tlast != in_last)) err_q <= 1'b1;
   end

   assign err_tlast = err_q;
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_ifmaps_rx.sv
module tb_axis_ifmaps_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic        cfg_start = 1'b0;
   logic [11:0] input_channel_size = '0;
   logic [15:0] vector_count = '0;
   logic [31:0] ifmaps_to_preload;
   logic        load_ifmaps_preload;
   logic        preload_fifo_full = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        err_tlast;

   int total = 0;
   int bad   = 0;

`ifdef AXIS_IFMAPS_RX_TLAST_CHECK_EN
   localparam logic TLAST_ERR_EXP = 1'b1;
`else
   localparam logic TLAST_ERR_EXP = 1'b0;
`endif

   axis_ifmaps_rx dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .s_axis_tdata        (s_axis_tdata),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tready       (s_axis_tready),
      .s_axis_tlast        (s_axis_tlast),
      .cfg_start           (cfg_start),
      .input_channel_size  (input_channel_size),
      .vector_count        (vector_count),
      .ifmaps_to_preload   (ifmaps_to_preload),
      .load_ifmaps_preload (load_ifmaps_preload),
      .preload_fifo_full   (preload_fifo_full),
      .busy                (busy),
      .frame_done          (frame_done),
      .err_tlast           (err_tlast)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // per-frame observations
   logic [31:0] base;
   int sent, loaded, order_bad, dones, gaps, last_load_cyc, done_cyc;
   int hold_loads, hold_ready, ready_after_in;
   logic err_at_done;

   task automatic start_cfg(input logic [11:0] c, input logic [15:0] v);
      @(negedge clk);
      input_channel_size = c;
      vector_count       = v;
      cfg_start          = 1'b1;
      @(negedge clk);
      cfg_start          = 1'b0;
   endtask

   // Drives one frame cycle by cycle; full is forced high for [fs, fs+fl).
   task automatic run_frame(input int exp_n, input int pv, input int pf, input int tlast_at,
                            input int fs, input int fl, input int budget);
      int tl;
      tl = (tlast_at < 0) ? exp_n - 1 : tlast_at;
      sent = 0; loaded = 0; order_bad = 0; dones = 0; gaps = 0;
      last_load_cyc = -1; done_cyc = -1; hold_loads = 0; hold_ready = 0; ready_after_in = 0;
      err_at_done = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (done_cyc >= 0 && cyc > done_cyc + 3) break;
         s_axis_tvalid     = ($urandom_range(99, 0) < pv);
         s_axis_tdata      = base + 32'(sent);
         s_axis_tlast      = (sent == tl);
         preload_fifo_full = (cyc >= fs && cyc < fs + fl) ? 1'b1 : ($urandom_range(99, 0) < pf);
         #1;
         if (load_ifmaps_preload) begin
            if (ifmaps_to_preload !== base + 32'(loaded)) order_bad++;
            if (last_load_cyc >= 0 && cyc != last_load_cyc + 1) gaps++;
            last_load_cyc = cyc;
            loaded++;
         end
         if (cyc >= fs && cyc < fs + fl) begin
            if (load_ifmaps_preload) hold_loads++;
            if (cyc >= fs + 2 && s_axis_tready) hold_ready++;
         end
         if (sent == exp_n && s_axis_tready) ready_after_in++;
         if (s_axis_tvalid && s_axis_tready) sent++;
         if (frame_done) begin
            dones++;
            done_cyc    = cyc;
            err_at_done = err_tlast;
         end
         @(negedge clk);
      end
      s_axis_tvalid     = 1'b0;
      s_axis_tlast      = 1'b0;
      preload_fifo_full = 1'b0;
   endtask

   initial begin
      // reset values
      #12;
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_load",   32'(load_ifmaps_preload), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(frame_done), 32'd0);
      chk("rst_err",    32'(err_tlast), 32'd0);
      chk("rst_data",   ifmaps_to_preload, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: C=256 -> 43 beats/vector, 2 vectors, back-to-back
      base = 32'h1100_0000;
      start_cfg(12'd256, 16'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      run_frame(86, 100, 0, -1, 1000, 0, 400);
      chk("t1_loads", 32'(loaded), 32'd86);
      chk("t1_order", 32'(order_bad), 32'd0);
      chk("t1_gaps",  32'(gaps), 32'd0);
      chk("t1_dones", 32'(dones), 32'd1);
      chk("t1_done_lat", 32'(done_cyc - last_load_cyc), 32'd1);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_err", 32'(err_at_done), 32'd0);

      // 2: C=6 -> 2 beats/vector, 3 vectors; beat 7 stays offered
      base = 32'h2200_0000;
      start_cfg(12'd6, 16'd3);
      run_frame(6, 100, 0, -1, 1000, 0, 200);
      chk("t2_accepts", 32'(sent), 32'd6);
      chk("t2_loads",   32'(loaded), 32'd6);
      chk("t2_ready_after", 32'(ready_after_in), 32'd0);
      chk("t2_order",   32'(order_bad), 32'd0);
      chk("t2_dones",   32'(dones), 32'd1);

      // 3: packer full for 10 cycles mid-frame
      base = 32'h3300_0000;
      start_cfg(12'd256, 16'd2);
      run_frame(86, 100, 0, -1, 20, 10, 400);
      chk("t3_hold_loads", 32'(hold_loads), 32'd0);
      chk("t3_hold_ready", 32'(hold_ready), 32'd0);
      chk("t3_loads", 32'(loaded), 32'd86);
      chk("t3_order", 32'(order_bad), 32'd0);
      chk("t3_dones", 32'(dones), 32'd1);

      // 4: random valid/full, C=100 -> 17 beats x 4 vectors
      base = 32'h4400_0000;
      start_cfg(12'd100, 16'd4);
      run_frame(68, 50, 30, -1, 1000, 0, 3000);
      chk("t4_loads",   32'(loaded), 32'd68);
      chk("t4_accepts", 32'(sent), 32'd68);
      chk("t4_order",   32'(order_bad), 32'd0);
      chk("t4_dones",   32'(dones), 32'd1);

      // 5: TLAST on beat 5 of a 43-beat frame, absent on the final beat
      base = 32'h5500_0000;
      start_cfg(12'd256, 16'd1);
      run_frame(43, 100, 0, 4, 1000, 0, 300);
      chk("t5_loads", 32'(loaded), 32'd43);
      chk("t5_err_at_done", 32'(err_at_done), 32'(TLAST_ERR_EXP));
      chk("t5_err_after", 32'(err_tlast), 32'(TLAST_ERR_EXP));
      base = 32'h5600_0000;
      start_cfg(12'd6, 16'd1);
      chk("t5_err_cleared", 32'(err_tlast), 32'd0);
      run_frame(2, 100, 0, -1, 1000, 0, 100);
      chk("t5_clean_err", 32'(err_at_done), 32'd0);
      chk("t5_clean_dones", 32'(dones), 32'd1);

      // 6: reset mid-frame, zero-channel config ignored, then a clean frame
      base = 32'h6600_0000;
      start_cfg(12'd256, 16'd2);
      sent = 0;
      for (int cyc = 0; cyc < 100 && sent < 20; cyc++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = base + 32'(sent);
         #1;
         if (s_axis_tready) sent++;
         @(negedge clk);
      end
      chk("t6_sent20", 32'(sent), 32'd20);
      #2;
      rst_n = 1'b0;
      #1;
      s_axis_tvalid = 1'b0;
      chk("t6_rst_tready", 32'(s_axis_tready), 32'd0);
      chk("t6_rst_load",   32'(load_ifmaps_preload), 32'd0);
      chk("t6_rst_busy",   32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_cfg(12'd0, 16'd5);
      repeat (3) @(negedge clk);
      #1;
      chk("t6_c0_busy",   32'(busy), 32'd0);
      chk("t6_c0_tready", 32'(s_axis_tready), 32'd0);
      base = 32'h6700_0000;
      start_cfg(12'd6, 16'd3);
      run_frame(6, 100, 0, -1, 1000, 0, 200);
      chk("t6_loads", 32'(loaded), 32'd6);
      chk("t6_order", 32'(order_bad), 32'd0);
      chk("t6_dones", 32'(dones), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
